voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI interpreter and the per-voice oscillator datapaths (phase accumulator, waveform generation and mixer).
- Accepts note-on/note-off events through a valid/ready handshake and assigns each note to one of NUM_VOICES voice slots.
- Steals the oldest sounding voice when all slots are busy.
- Drives per-voice gate, note, velocity and trigger outputs that the oscillator and envelope blocks consume.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..16).
- NOTE_BITS, 7, MIDI note number width.
- VEL_BITS, 7, MIDI velocity width.
- AGE_BITS, 8, per-voice age counter width; saturates at 2^AGE_BITS-1.

Ports:
- i_Clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event (high only in IDLE).
- ev_is_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_BITS  note number.
- ev_vel  in  VEL_BITS  velocity; ignored for note-off.
- all_off  in  1  panic: clear all gates.
- voice_gate  out  NUM_VOICES  1 = voice sounding.
- voice_note  out  NUM_VOICES*NOTE_BITS  note of voice i at bits [i*NOTE_BITS +: NOTE_BITS].
- voice_vel  out  NUM_VOICES*VEL_BITS  velocity of voice i, packed the same way.
- voice_trig  out  NUM_VOICES  one-cycle pulse when voice i is (re)started.
- steal  out  1  one-cycle pulse when a sounding voice was taken for a new note.

Behaviour:
- Reset (async): state IDLE, ev_ready=1, all gates/notes/velocities/ages=0, voice_trig=0, steal=0. Events presented while reset is high are ignored.
- FSM states IDLE, SCAN, COMMIT. ev_ready = (state==IDLE), combinational.
- IDLE: on ev_valid&&ev_ready at edge k, the event is latched (is_on, note, vel) and the FSM enters SCAN with idx=0.
  - A note-on with vel==0 is latched as a note-off.
- SCAN, edges k+1..k+NUM_VOICES: examine slot idx, one per cycle, idx increments; record:
  - match: lowest index with gate=1 and note==latched note.
  - free: lowest index with gate=0.
  - oldest: gated slot with the largest age; ties go to the lowest index.
- After the last slot: COMMIT. The commit edge is k+NUM_VOICES+1; the FSM returns to IDLE on that edge.
- Latency: outputs reflect the event after edge k+NUM_VOICES+1. ev_ready is high again in the following cycle, so throughput is one event per NUM_VOICES+2 cycles.
- Commit, note-on (target chosen by first matching rule):
  - match exists: retrigger that slot; vel updated.
  - else free exists: use the free slot.
  - else: use the oldest slot and pulse steal.
  - Target slot: gate=1, note and vel written, age=0, voice_trig[target] pulses one cycle.
  - Every other gated slot: age+1, saturating. Non-gated slots hold their age.
- Commit, note-off:
  - match exists: gate cleared; note, vel and age retained.
  - no match: no change.
  - No trig or steal pulse for any note-off.
- voice_trig and steal are registered pulses, high exactly the one cycle after the commit edge, otherwise 0.
- all_off=1 at any edge, highest priority below reset:
  - All gates clear, FSM forced to IDLE, any in-flight event dropped.
  - No trig or steal pulse.
  - Notes and vel retained, ages cleared.
- ev_note and ev_vel are sampled only at the acceptance edge. Input changes during SCAN/COMMIT have no effect.
- Sequential, fully synchronous to i_Clk except reset. No combinational path from ev_* inputs to the voice_* outputs.

Test Plan (NUM_VOICES=4):
- Reset, then note-on 60/vel 100 accepted at edge k.
  - ev_ready low for 5 cycles.
  - After edge k+5: voice_gate=0001, voice 0 note=60, vel=100, voice_trig=0001 for exactly one cycle.
- Note-ons 60, 62, 64, 67, then 69.
  - Gates 1111 after four events.
  - 69 steals voice 0 (oldest, age 3): steal=1 and trig=0001 for one cycle; voice 0 note=69; gates remain 1111.
- Gates 1111 holding notes 60/62/64/67; note-off 62.
  - voice_gate=1101, voice 1 note still 62.
  - A following note-off 50 (no match) leaves all outputs unchanged, with no pulses.
- Note-on 60 vel 100, then note-on 60 vel 40.
  - The second event retriggers voice 0: vel=40, trig=0001, gate=0001, no second voice used, steal=0.
- Note-on 64 vel 0 while 64 is sounding on voice 2.
  - Treated as note-off: gate bit 2 cleared, no trig.
- all_off asserted during SCAN of a note-on.
  - Gates 0000, ev_ready=1 next cycle.
  - The dropped event never appears, with no trig.
  - Async reset mid-SCAN clears all outputs immediately.

Source files
------------

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// voice_allocator : polyphonic note-to-voice scheduler with oldest-voice steal
// Rev 1.0
// ============================================================================
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_BITS  = 7,
    parameter int VEL_BITS   = 7,
    parameter int AGE_BITS   = 8
) (
    input  logic                             i_Clk,
    input  logic                             reset,
    input  logic                             ev_valid,
    output logic                             ev_ready,
    input  logic                             ev_is_on,
    input  logic [NOTE_BITS-1:0]             ev_note,
    input  logic [VEL_BITS-1:0]              ev_vel,
    input  logic                             all_off,
    output logic [NUM_VOICES-1:0]            voice_gate,
    output logic [NUM_VOICES*NOTE_BITS-1:0]  voice_note,
    output logic [NUM_VOICES*VEL_BITS-1:0]   voice_vel,
    output logic [NUM_VOICES-1:0]            voice_trig,
    output logic                             steal
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_BITS-1:0] AGE_MAX = '1;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NOTE_BITS-1:0] note_reg [NUM_VOICES];
    logic [VEL_BITS-1:0]  vel_reg  [NUM_VOICES];
    logic [AGE_BITS-1:0]  age_reg  [NUM_VOICES];

    logic                 lat_on;
    logic [NOTE_BITS-1:0] lat_note;
    logic [VEL_BITS-1:0]  lat_vel;
    logic [IDX_W-1:0]     idx;
    logic                 match_found, free_found, old_found;
    logic [IDX_W-1:0]     match_idx, free_idx, old_idx;
    logic [AGE_BITS-1:0]  old_age;
    logic [IDX_W-1:0]     target;
    logic                 do_steal;

    assign ev_ready = (state == IDLE);

    always_ff @(posedge i_Clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ev_valid) state_next = SCAN;
            SCAN:    if (idx == IDX_LAST) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (all_off) state_next = IDLE;
    end

    // Note-on target priority: retrigger a matching voice, else a free one, else steal.
    always_comb begin
        target   = old_idx;
        do_steal = 1'b0;
        if (match_found)     target = match_idx;
        else if (free_found) target = free_idx;
        else                 do_steal = 1'b1;
    end

    always_ff @(posedge i_Clk or posedge reset) begin
        if (reset) begin
            voice_gate  <= '0;
            voice_trig  <= '0;
            steal       <= 1'b0;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            lat_vel     <= '0;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_reg[i] <= '0;
                vel_reg[i]  <= '0;
                age_reg[i]  <= '0;
            end
        end else begin
            voice_trig <= '0;
            steal      <= 1'b0;
            if (all_off) begin
                voice_gate <= '0;
                for (int i = 0; i < NUM_VOICES; i++) age_reg[i] <= '0;
            end else begin
                case (state)
                    IDLE: if (ev_valid) begin
                        // Velocity-zero note-on is the running-status form of note-off.
                        lat_on      <= ev_is_on && (ev_vel != '0);
                        lat_note    <= ev_note;
                        lat_vel     <= ev_vel;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                    end
                    SCAN: begin
                        if (voice_gate[idx] && note_reg[idx] == lat_note && !match_found) begin
                            match_found <= 1'b1;
                            match_idx   <= idx;
                        end
                        if (!voice_gate[idx] && !free_found) begin
                            free_found <= 1'b1;
                            free_idx   <= idx;
                        end
                        // Strict compare keeps the lowest index on equal ages.
                        if (voice_gate[idx] && (!old_found || age_reg[idx] > old_age)) begin
                            old_found <= 1'b1;
                            old_idx   <= idx;
                            old_age   <= age_reg[idx];
                        end
                        idx <= idx + 1'b1;
                    end
                    COMMIT: begin
                        if (lat_on) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == target) begin
                                    voice_gate[i] <= 1'b1;
                                    note_reg[i]   <= lat_note;
                                    vel_reg[i]    <= lat_vel;
                                    age_reg[i]    <= '0;
                                    voice_trig[i] <= 1'b1;
                                end else if (voice_gate[i] && age_reg[i] != AGE_MAX) begin
                                    age_reg[i] <= age_reg[i] + 1'b1;
                                end
                            end
                            steal <= do_steal;
                        end else if (match_found) begin
                            voice_gate[match_idx] <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[g*NOTE_BITS +: NOTE_BITS] = note_reg[g];
        assign voice_vel[g*VEL_BITS +: VEL_BITS]    = vel_reg[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// tb_voice_allocator : scoreboard bench, event-level reference model vs. allocator
module tb_voice_allocator;
    localparam int N  = 4;
    localparam int NB = 7;
    localparam int VB = 7;
    localparam int AB = 8;
    localparam int AGE_MAX = (1 << AB) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              ev_valid, ev_is_on, all_off;
    logic              ev_ready, steal;
    logic [NB-1:0]     ev_note;
    logic [VB-1:0]     ev_vel;
    logic [N-1:0]      voice_gate, voice_trig;
    logic [N*NB-1:0]   voice_note;
    logic [N*VB-1:0]   voice_vel;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0]    gate;
        logic [N*NB-1:0] notes;
        logic [N*VB-1:0] vels;
        logic [N-1:0]    trig;
        logic            steal;
    } exp_t;

    exp_t q[$];
    int m_gate[N], m_note[N], m_vel[N], m_age[N];

    voice_allocator #(.NUM_VOICES(N), .NOTE_BITS(NB), .VEL_BITS(VB), .AGE_BITS(AB)) dut (
        .i_Clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_is_on(ev_is_on), .ev_note(ev_note), .ev_vel(ev_vel), .all_off(all_off),
        .voice_gate(voice_gate), .voice_note(voice_note), .voice_vel(voice_vel),
        .voice_trig(voice_trig), .steal(steal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.trig = '0;
        e.steal = 1'b0;
        for (int i = 0; i < N; i++) begin
            e.gate[i] = m_gate[i][0];
            e.notes[i*NB +: NB] = NB'(m_note[i]);
            e.vels[i*VB +: VB]  = VB'(m_vel[i]);
        end
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
    endfunction

    // Whole-event reference: choose voice from the allocation rules, then age everyone else.
    function automatic exp_t model_event(input bit on, input int note, input int vel);
        int match = -1, free = -1, old = -1, tgt;
        bit stl = 0;
        exp_t e;
        if (vel == 0) on = 0;
        for (int i = 0; i < N; i++) begin
            if (m_gate[i] != 0 && m_note[i] == note && match < 0) match = i;
            if (m_gate[i] == 0 && free < 0) free = i;
            if (m_gate[i] != 0 && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        tgt = -1;
        if (on) begin
            if (match >= 0)     tgt = match;
            else if (free >= 0) tgt = free;
            else begin tgt = old; stl = 1; end
            for (int i = 0; i < N; i++)
                if (i != tgt && m_gate[i] != 0 && m_age[i] < AGE_MAX) m_age[i]++;
            m_gate[tgt] = 1; m_note[tgt] = note; m_vel[tgt] = vel; m_age[tgt] = 0;
        end else if (match >= 0) begin
            m_gate[match] = 0;
        end
        e = snapshot();
        if (tgt >= 0) e.trig[tgt] = 1'b1;
        e.steal = stl;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 32'(ev_ready), 32'd1);
        chk({tag, "_gate"},  32'(voice_gate), 32'd0);
        chk({tag, "_note"},  32'(voice_note), 32'd0);
        chk({tag, "_vel"},   32'(voice_vel), 32'd0);
        chk({tag, "_trig"},  32'(voice_trig), 32'd0);
        chk({tag, "_steal"}, 32'(steal), 32'd0);
    endtask

    task automatic accept(input bit on, input int note, input int vel);
        int guard = 0;
        @(negedge clk);
        while (!ev_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!ev_ready) chk("ready_timeout", 32'(ev_ready), 32'd1);
        ev_valid = 1'b1; ev_is_on = on; ev_note = NB'(note); ev_vel = VB'(vel);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        ev_is_on = 1'($urandom); ev_note = NB'($urandom); ev_vel = VB'($urandom);
    endtask

    task automatic send(input bit on, input int note, input int vel);
        int cnt = 0;
        accept(on, note, vel);
        q.push_back(model_event(on, note, vel));
        while (cnt < 50) begin
            @(negedge clk);
            if (ev_ready) break;
            cnt++;
        end
        chk("ready_low_cycles", 32'(cnt), 32'(N + 1));
    endtask

    task automatic abort_alloff(input int note, input int vel);
        accept(1'b1, note, vel);
        @(negedge clk); @(negedge clk);
        all_off = 1'b1;
        @(posedge clk); #1;
        all_off = 1'b0;
        for (int i = 0; i < N; i++) begin m_gate[i] = 0; m_age[i] = 0; end
        q.push_back(snapshot());
        @(negedge clk);
        chk("alloff_ready", 32'(ev_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: each rising ev_ready marks a commit (or an abort); all other cycles must be pulse-free.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = ev_ready;
            end else begin
                if (ev_ready && !prev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_commit", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("gate",  32'(voice_gate), 32'(e.gate));
                        chk("notes", 32'(voice_note), 32'(e.notes));
                        chk("vels",  32'(voice_vel),  32'(e.vels));
                        chk("trig",  32'(voice_trig), 32'(e.trig));
                        chk("steal", 32'(steal),      32'(e.steal));
                    end
                end else begin
                    chk("idle_trig",  32'(voice_trig), 32'd0);
                    chk("idle_steal", 32'(steal),      32'd0);
                end
                prev = ev_ready;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; ev_valid = 1'b0; ev_is_on = 1'b0; ev_note = '0; ev_vel = '0; all_off = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("por");
        reset = 1'b0;

        // First allocation, fill, then oldest-voice steal.
        send(1, 60, 100);
        send(1, 62, 90); send(1, 64, 80); send(1, 67, 70);
        chk("full_gates", 32'(voice_gate), 32'hF);
        send(1, 69, 55);
        chk("steal_v0_note", 32'(voice_note[NB-1:0]), 32'd69);

        // Note-off of a sounding note, then an unmatched note-off.
        pulse_reset();
        send(1, 60, 100); send(1, 62, 90); send(1, 64, 80); send(1, 67, 70);
        send(0, 62, 0);
        chk("off_gate", 32'(voice_gate), 32'hD);
        send(0, 50, 33);

        // Retrigger, then velocity-zero note-on acts as note-off.
        pulse_reset();
        send(1, 60, 100); send(1, 60, 40);
        chk("retrig_gate", 32'(voice_gate), 32'h1);
        send(1, 62, 10); send(1, 64, 20); send(1, 64, 0);

        // Panic mid-scan, then async reset mid-scan.
        abort_alloff(71, 99);
        send(1, 72, 5);
        accept(1, 73, 88);
        @(posedge clk); #2;
        reset = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Age saturation: voice 1 must be oldest despite an 8-bit age that would wrap.
        send(1, 60, 1); send(1, 61, 2);
        for (int i = 0; i < 256; i++) send(1, 60, 3);
        send(1, 62, 4); send(1, 63, 5); send(1, 64, 6);
        chk("sat_steal_v1_note", 32'(voice_note[2*NB-1:NB]), 32'd64);

        // Randomized traffic over a narrow note range so matches and steals are frequent.
        pulse_reset();
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5) abort_alloff(int'($urandom_range(60, 67)), int'($urandom_range(1, 127)));
            else send(r < 65, int'($urandom_range(60, 67)),
                      (r % 7 == 0) ? 0 : int'($urandom_range(1, 127)));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
